// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - measures period and high time of an asynchronous clock, flags lock/period/stuck
// Optional duty-cycle check enabled by defining CLOCK_MONITOR_DUTY_CHECK_EN (adds exp_high/err_duty).
module clock_monitor #(
  parameter int CNT_W       = 12,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  input  logic             err_clr,
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  input  logic [CNT_W-1:0] exp_high,
  output logic             err_duty,
`endif
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RISE = 2'd1, MEAS = 2'd2} state_t;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [CNT_W-1:0]       per_cnt_q, high_cnt_q;
  logic [CNT_W-1:0]       meas_period_q, meas_high_q;
  logic [3:0]             lock_cnt_q;
  logic                   meas_valid_q, locked_q, err_period_q, stuck_q, per_bad_q;

  logic             sync_in, rise_det, fall_det;
  logic [CNT_W:0]   per_diff_d;
  logic             per_bad, meas_bad, meas_evt, sat_evt;

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign rise_det = sync_in & ~edge_q;
  assign fall_det = ~sync_in & edge_q;

  // One extra bit keeps the absolute difference from wrapping.
  always_comb begin
    per_diff_d = '0;
    if (per_cnt_q >= exp_period) per_diff_d = {1'b0, per_cnt_q} - {1'b0, exp_period};
    else                         per_diff_d = {1'b0, exp_period} - {1'b0, per_cnt_q};
  end
  assign per_bad = per_diff_d > {1'b0, tol};

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  logic [CNT_W:0] high_diff_d;
  logic           duty_bad, err_duty_q, duty_bad_q;
  always_comb begin
    high_diff_d = '0;
    if (high_cnt_q >= exp_high) high_diff_d = {1'b0, high_cnt_q} - {1'b0, exp_high};
    else                        high_diff_d = {1'b0, exp_high} - {1'b0, high_cnt_q};
  end
  assign duty_bad = high_diff_d > {1'b0, tol};
  assign meas_bad = per_bad | duty_bad;
  assign err_duty = err_duty_q;
`else
  assign meas_bad = per_bad;
`endif

  assign meas_evt = en && (state_q == MEAS) && rise_det;
  assign sat_evt  = en && (state_q != IDLE) && !rise_det && (per_cnt_q == '1);

  // A clear landing on the cycle an error is reported (rise edge or meas_valid cycle) loses to the set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      edge_q        <= 1'b0;
      per_cnt_q     <= '0;
      high_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      lock_cnt_q    <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_period_q  <= 1'b0;
      stuck_q       <= 1'b0;
      per_bad_q     <= 1'b0;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
      err_duty_q    <= 1'b0;
      duty_bad_q    <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], mon_in};
      edge_q       <= sync_in;
      meas_valid_q <= 1'b0;
      err_period_q <= (meas_evt && per_bad) ||
                      (err_period_q && !(err_clr && !(meas_valid_q && per_bad_q)));
      stuck_q      <= sat_evt || (stuck_q && !err_clr);
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
      err_duty_q   <= (meas_evt && duty_bad) ||
                      (err_duty_q && !(err_clr && !(meas_valid_q && duty_bad_q)));
`endif
      if (!en) begin
        state_q    <= IDLE;
        per_cnt_q  <= '0;
        high_cnt_q <= '0;
        lock_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= WAIT_RISE;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
          end
          WAIT_RISE, MEAS: begin
            if (rise_det) begin
              state_q    <= MEAS;
              per_cnt_q  <= CNT_W'(1);
              high_cnt_q <= CNT_W'(1);
              if (state_q == MEAS) begin
                meas_period_q <= per_cnt_q;
                meas_high_q   <= high_cnt_q;
                meas_valid_q  <= 1'b1;
                per_bad_q     <= per_bad;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
                duty_bad_q    <= duty_bad;
`endif
                if (meas_bad) begin
                  lock_cnt_q <= '0;
                  locked_q   <= 1'b0;
                end else begin
                  if (lock_cnt_q < LOCK_MAX) lock_cnt_q <= lock_cnt_q + 4'd1;
                  if (lock_cnt_q >= LOCK_MAX - 4'd1) locked_q <= 1'b1;
                end
              end
            end else if (per_cnt_q == '1) begin
              state_q    <= WAIT_RISE;
              per_cnt_q  <= '0;
              high_cnt_q <= '0;
              lock_cnt_q <= '0;
              locked_q   <= 1'b0;
            end else begin
              per_cnt_q <= per_cnt_q + 1'b1;
              if (sync_in && !fall_det) high_cnt_q <= high_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign err_period  = err_period_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - directed self-checking bench for clock_monitor
// Duty-check vectors run only when CLOCK_MONITOR_DUTY_CHECK_EN is defined.
module tb_clock_monitor;
  localparam int CNT_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, mon_in, err_clr_main, err_clr_mon, err_clr;
  logic [CNT_W-1:0] exp_period, tol, meas_period, meas_high;
  logic             meas_valid, locked, err_period, stuck;
  logic             en_s, err_clr_s;
  logic [5:0]       meas_period_s, meas_high_s;
  logic             meas_valid_s, locked_s, err_period_s, stuck_s;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
  logic [CNT_W-1:0] exp_high;
  logic             err_duty, err_duty_s;
`endif

  assign err_clr = err_clr_main | err_clr_mon;

  clock_monitor #(.CNT_W(CNT_W), .LOCK_CNT(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_in),
    .exp_period(exp_period), .tol(tol), .err_clr(err_clr),
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    .exp_high(exp_high), .err_duty(err_duty),
`endif
    .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
    .locked(locked), .err_period(err_period), .stuck(stuck)
  );

  clock_monitor #(.CNT_W(6), .LOCK_CNT(4), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .mon_in(1'b0),
    .exp_period(6'd10), .tol(6'd0), .err_clr(err_clr_s),
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    .exp_high(6'd5), .err_duty(err_duty_s),
`endif
    .meas_period(meas_period_s), .meas_high(meas_high_s), .meas_valid(meas_valid_s),
    .locked(locked_s), .err_period(err_period_s), .stuck(stuck_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Snapshot of every meas_valid pulse, plus an optional err_clr injected on that same cycle.
  int               valid_cnt;
  logic [CNT_W-1:0] last_period, last_high;
  logic             last_locked, last_err;
  logic             lock_hist [0:255];
  logic             arm_clr, clr_done, clr_result;

  initial begin
    valid_cnt   = 0;
    clr_done    = 1'b0;
    clr_result  = 1'b0;
    err_clr_mon = 1'b0;
    last_period = '0;
    last_high   = '0;
    last_locked = 1'b0;
    last_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        valid_cnt++;
        last_period = meas_period;
        last_high   = meas_high;
        last_locked = locked;
        last_err    = err_period;
        if (valid_cnt < 256) lock_hist[valid_cnt] = locked;
        if (arm_clr && !clr_done) begin
          err_clr_mon = 1'b1;
          @(negedge clk);
          clr_result  = err_period;
          err_clr_mon = 1'b0;
          clr_done    = 1'b1;
        end
      end
    end
  end

  task automatic run_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      mon_in = (i < h);
    end
  endtask

  int v0;

  initial begin
    rst = 1'b1; en = 1'b0; mon_in = 1'b0; err_clr_main = 1'b0; arm_clr = 1'b0;
    exp_period = 12'd10; tol = 12'd0; en_s = 1'b0; err_clr_s = 1'b0;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    exp_high = 12'd5;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_meas_period", 32'(meas_period), 32'd0);
    check_eq("rst_meas_high", 32'(meas_high), 32'd0);
    check_eq("rst_meas_valid", 32'(meas_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err_period", 32'(err_period), 32'd0);
    check_eq("rst_stuck", 32'(stuck), 32'd0);
    rst = 1'b0;

    // Stuck detection on the 6-bit instance with its input held low.
    @(negedge clk);
    en_s = 1'b1;
    repeat (62) @(negedge clk);
    check_eq("stuck_early", 32'(stuck_s), 32'd0);
    repeat (6) @(negedge clk);
    check_eq("stuck_set", 32'(stuck_s), 32'd1);
    check_eq("stuck_state", 32'(int'(dut_s.state_q)), 32'd1);
    check_eq("stuck_locked", 32'(locked_s), 32'd0);
    err_clr_s = 1'b1;
    @(negedge clk);
    err_clr_s = 1'b0;
    check_eq("stuck_clr", 32'(stuck_s), 32'd0);
    en_s = 1'b0;

    // Nominal lock: period 10, high 5, tol 0.
    en = 1'b1;
    repeat (3) @(negedge clk);
    repeat (5) run_period(10, 5);
    check_eq("nom_valid_cnt", 32'(valid_cnt), 32'd4);
    check_eq("nom_period", 32'(last_period), 32'd10);
    check_eq("nom_high", 32'(last_high), 32'd5);
    check_eq("nom_lock_3rd", 32'(lock_hist[3]), 32'd0);
    check_eq("nom_lock_4th", 32'(lock_hist[4]), 32'd1);
    check_eq("nom_err", 32'(last_err), 32'd0);

    // One long period outside tol=2, then relock with the sticky error kept.
    tol = 12'd2;
    run_period(13, 5);
    run_period(10, 5);
    check_eq("bad_period", 32'(last_period), 32'd13);
    check_eq("bad_err", 32'(last_err), 32'd1);
    check_eq("bad_locked", 32'(last_locked), 32'd0);
    repeat (4) run_period(10, 5);
    check_eq("relock_locked", 32'(last_locked), 32'd1);
    check_eq("relock_err_sticky", 32'(last_err), 32'd1);

    // Plain clear, then a clear coinciding with a new error report.
    @(negedge clk); err_clr_main = 1'b1;
    @(negedge clk); err_clr_main = 1'b0;
    check_eq("clr_err", 32'(err_period), 32'd0);
    run_period(14, 5);
    arm_clr = 1'b1;
    run_period(10, 5);
    arm_clr = 1'b0;
    check_eq("clr_race_done", 32'(clr_done), 32'd1);
    check_eq("clr_race_err", 32'(clr_result), 32'd1);
    check_eq("clr_race_period", 32'(last_period), 32'd14);
    repeat (4) run_period(10, 5);
    check_eq("relock2_locked", 32'(last_locked), 32'd1);

    // Reset mid-period while locked.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check_eq("pre_rst_locked", 32'(locked), 32'd1);
      if (i == 8) begin
        check_eq("mid_rst_meas_period", 32'(meas_period), 32'd0);
        check_eq("mid_rst_meas_high", 32'(meas_high), 32'd0);
        check_eq("mid_rst_meas_valid", 32'(meas_valid), 32'd0);
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_err_period", 32'(err_period), 32'd0);
        check_eq("mid_rst_stuck", 32'(stuck), 32'd0);
      end
      mon_in = (i < 5);
      rst    = (i == 7);
    end
    v0 = valid_cnt;
    run_period(10, 5);
    check_eq("post_rst_no_valid", 32'(valid_cnt), 32'(v0));
    run_period(12, 6);
    check_eq("post_rst_valid", 32'(valid_cnt), 32'(v0 + 1));
    check_eq("post_rst_period", 32'(last_period), 32'd10);
    check_eq("post_rst_high", 32'(last_high), 32'd5);

    // Tolerance boundaries: diff exactly tol on both sides.
    run_period(8, 4);
    check_eq("tol_hi_period", 32'(last_period), 32'd12);
    check_eq("tol_hi_high", 32'(last_high), 32'd6);
    check_eq("tol_hi_err", 32'(last_err), 32'd0);
    run_period(10, 5);
    check_eq("tol_lo_period", 32'(last_period), 32'd8);
    check_eq("tol_lo_high", 32'(last_high), 32'd4);
    check_eq("tol_lo_err", 32'(last_err), 32'd0);

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    tol = 12'd1;
    run_period(10, 8);
    run_period(10, 5);
    check_eq("duty_high", 32'(last_high), 32'd8);
    check_eq("duty_err_duty", 32'(err_duty), 32'd1);
    check_eq("duty_err_period", 32'(err_period), 32'd0);
    check_eq("duty_locked", 32'(last_locked), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
